// File: rtl/store_buffer_pkg.sv
// Shared constants and FSM encoding for the posted-write store buffer.
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);
  localparam int SB_CNT_W = SB_PTR_W + 1;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_FENCE = 2'd2
  } sb_state_e;
endpackage

// File: rtl/store_buffer_chk.sv
// Interface checks for the store buffer's CPU-side strobes.
module store_buffer_chk (
  input logic clk_i,
  input logic rst_i,
  input logic rd_i,
  input logic wr_i
);
  a_rd_wr_exclusive: assert property (@(posedge clk_i) disable iff (rst_i) !(rd_i && wr_i));
endmodule

// File: rtl/store_buffer_fifo.sv
// Circular store FIFO: word tags plus data, head/tail pointers and an occupancy count.
module store_buffer_fifo import store_buffer_pkg::*; #(
  parameter int DEPTH  = SB_DEPTH,
  parameter int TAG_W  = 30,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enq_i,
  input  logic                    deq_i,
  input  logic [TAG_W-1:0]        enq_tag_i,
  input  logic [DATA_W-1:0]       enq_data_i,
  output logic [DEPTH*TAG_W-1:0]  tags_o,
  output logic [DEPTH*DATA_W-1:0] data_o,
  output logic [DEPTH-1:0]        valid_o,
  output logic [PTR_W-1:0]        head_o,
  output logic [CNT_W-1:0]        count_o
);
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];

  // Age of slot idx relative to head, wrapping modulo DEPTH.
  function automatic logic [PTR_W-1:0] rel_age(input int idx, input logic [PTR_W-1:0] h);
    rel_age = PTR_W'(idx) - h;
  endfunction

  always_comb begin
    head_d  = deq_i ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq_i ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(enq_i) - CNT_W'(deq_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity comes from the count.
  always_ff @(posedge clk_i) begin
    if (enq_i) begin
      tag_q[tail_q] <= enq_tag_i;
      dat_q[tail_q] <= enq_data_i;
    end
  end

  always_comb begin
    tags_o  = '0;
    data_o  = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tags_o[i*TAG_W +: TAG_W]   = tag_q[i];
      data_o[i*DATA_W +: DATA_W] = dat_q[i];
      valid_o[i]                 = {1'b0, rel_age(i, head_q)} < count_q;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;
endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: forwards youngest matching store to loads, drains to memory when the port is idle.
module store_buffer import store_buffer_pkg::*; #(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     cpu_MemWrite,
  input  logic                     cpu_MemRead,
  output logic [DATA_W-1:0]        cpu_rdata,
  input  logic                     fence_req,
  output logic                     sb_stall,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic                     mem_MemWrite,
  output logic                     mem_MemRead,
  input  logic [DATA_W-1:0]        mem_read_data,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - 2;

  logic [DEPTH*TAG_W-1:0]  tags_s;
  logic [DEPTH*DATA_W-1:0] data_s;
  logic [DEPTH-1:0]        valid_s;
  logic [PTR_W-1:0]        head_s, sel_s;
  logic [CNT_W-1:0]        count_s, count_next_s;
  logic                    match_s, hit_s, load_miss_s, drain_s, stall_s, enq_s;
  logic [DATA_W-1:0]       hit_data_s;
  sb_state_e               state_q, state_d;

  store_buffer_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .enq_i      (enq_s),
    .deq_i      (drain_s),
    .enq_tag_i  (cpu_addr[ADDR_W-1:2]),
    .enq_data_i (cpu_wdata),
    .tags_o     (tags_s),
    .data_o     (data_s),
    .valid_o    (valid_s),
    .head_o     (head_s),
    .count_o    (count_s)
  );

  store_buffer_chk u_chk (
    .clk_i (clk),
    .rst_i (rst),
    .rd_i  (cpu_MemRead),
    .wr_i  (cpu_MemWrite)
  );

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = '0;
    sel_s      = '0;
    match_s    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_s      = head_s + PTR_W'(i);
      match_s    = cpu_MemRead && valid_s[sel_s] &&
                   (tags_s[sel_s*TAG_W +: TAG_W] == cpu_addr[ADDR_W-1:2]);
      hit_data_s = match_s ? data_s[sel_s*DATA_W +: DATA_W] : hit_data_s;
      hit_s      = hit_s | match_s;
    end
  end

  always_comb begin
    load_miss_s    = cpu_MemRead && !hit_s;
    drain_s        = (count_s != '0) && !load_miss_s;
    stall_s        = (cpu_MemWrite && (count_s == CNT_W'(DEPTH)) && !drain_s) ||
                     (fence_req && (state_q != SB_IDLE));
    enq_s          = cpu_MemWrite && !cpu_MemRead && !stall_s &&
                     ((count_s != CNT_W'(DEPTH)) || drain_s);
    count_next_s   = count_s + CNT_W'(enq_s) - CNT_W'(drain_s);
    mem_MemRead    = load_miss_s;
    mem_MemWrite   = drain_s;
    mem_addr       = drain_s     ? {tags_s[head_s*TAG_W +: TAG_W], 2'b00} :
                     load_miss_s ? cpu_addr : '0;
    mem_write_data = drain_s ? data_s[head_s*DATA_W +: DATA_W] : '0;
    cpu_rdata      = hit_s ? hit_data_s : (load_miss_s ? mem_read_data : '0);
    sb_stall       = stall_s;
    sb_count       = count_s;
    sb_empty       = (count_s == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE:  state_d = (count_next_s != '0) ? SB_DRAIN : SB_IDLE;
      SB_DRAIN: state_d = (count_next_s == '0) ? SB_IDLE  : (fence_req ? SB_FENCE : SB_DRAIN);
      SB_FENCE: state_d = (count_next_s == '0) ? SB_IDLE  : (fence_req ? SB_FENCE : SB_DRAIN);
      default:  state_d = SB_IDLE;
    endcase
  end
endmodule
